// File: rtl/dec_onehot_pkg.sv
// Shared types and decode helper for the one-hot decoder pipeline.
// Used by the RTL and by its testbench reference model.
package dec_onehot_pkg;

   localparam int CODE_W_DEF = 2;
   localparam int MAX_OUT_W  = 64;

   typedef enum logic {
      IDLE,
      SCAN
   } scan_state_e;

   function automatic logic [MAX_OUT_W-1:0] onehot_of(
      input logic [31:0] code,
      input logic        en
   );
      logic [MAX_OUT_W-1:0] w;
      w = en ? (64'd1 << code) : '0;
      return w;
   endfunction

endpackage

// File: rtl/dec_onehot_fifo2.sv
// Two-entry output buffer; head entry always sits in mem0_q.
// Pushes at full and pops when empty are dropped.
module dec_onehot_fifo2 #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic [1:0]   count
);

   logic [W-1:0] mem0_q;
   logic [W-1:0] mem1_q;
   logic [1:0]   cnt_q;
   logic         do_push;
   logic         do_pop;

   assign do_push = push && (cnt_q != 2'd2);
   assign do_pop  = pop && (cnt_q != 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem0_q <= '0;
         mem1_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         unique case ({do_push, do_pop})
            2'b10: begin
               if (cnt_q == 2'd0) mem0_q <= din;
               else               mem1_q <= din;
               cnt_q <= cnt_q + 2'd1;
            end
            2'b01: begin
               mem0_q <= mem1_q;
               mem1_q <= '0;
               cnt_q  <= cnt_q - 2'd1;
            end
            2'b11: begin
               // Count is unchanged; the new word lands behind the survivor.
               if (cnt_q == 2'd1) begin
                  mem0_q <= din;
               end else begin
                  mem0_q <= mem1_q;
                  mem1_q <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign head  = (cnt_q != 2'd0) ? mem0_q : '0;
   assign count = cnt_q;

endmodule

// File: rtl/dec_onehot_pipe.sv
// Handshaked binary-to-one-hot decoder with a 2-entry output buffer.
// Define DEC_ONEHOT_SCAN_EN to build the walking-one scan generator.
module dec_onehot_pipe
   import dec_onehot_pkg::*;
#(
   parameter int CODE_W = CODE_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CODE_W-1:0]        in_code,
   input  logic                     in_en,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [(1<<CODE_W)-1:0]   out_y,
   input  logic                     scan_start,
   output logic                     scan_busy
);

   localparam int OUT_W = 1 << CODE_W;

   logic [1:0]           cnt;
   logic [OUT_W-1:0]     head;
   logic [OUT_W-1:0]     push_word;
   logic [MAX_OUT_W-1:0] wide;
   logic [31:0]          dec_code;
   logic                 dec_en;
   logic                 push;
   logic                 pop;
   logic                 scan_push;
   logic [CODE_W-1:0]    idx;
   logic                 unused_wide;

`ifdef DEC_ONEHOT_SCAN_EN
   scan_state_e       state_q;
   scan_state_e       state_d;
   logic [CODE_W-1:0] idx_q;
   logic [CODE_W-1:0] idx_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      scan_push = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (scan_start && (cnt == 2'd0)) state_d = SCAN;
         end
         SCAN: begin
            if (cnt != 2'd2) begin
               scan_push = 1'b1;
               if (idx_q == CODE_W'(OUT_W - 1)) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign scan_busy = (state_q == SCAN);
   assign idx       = idx_q;
`else
   logic unused_scan;

   assign unused_scan = scan_start;
   assign scan_push   = 1'b0;
   assign scan_busy   = 1'b0;
   assign idx         = '0;
`endif

   // rst gates in_ready directly so it reads 0 for the whole reset window.
   assign in_ready  = !rst && (cnt != 2'd2) && !scan_busy;
   assign out_valid = (cnt != 2'd0);
   assign out_y     = head;

   assign dec_code  = scan_push ? 32'(idx) : 32'(in_code);
   assign dec_en    = scan_push | in_en;
   assign wide      = onehot_of(dec_code, dec_en);
   assign push_word = wide[OUT_W-1:0];
   assign unused_wide = ^wide;

   assign push = scan_push | (in_valid & in_ready);
   assign pop  = out_valid & out_ready;

   dec_onehot_fifo2 #(
      .W(OUT_W)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .pop  (pop),
      .din  (push_word),
      .head (head),
      .count(cnt)
   );

endmodule
